// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Owns the architectural HI/LO registers and sequences an iterative radix-2
//   multiply/divide engine for the pipelined MIPS core. Accepts MULT, MULTU,
//   DIV, DIVU, MTHI, MTLO, MFHI and MFLO from EX. It requests a pipeline stall
//   when any of these ops meets a busy engine.
//
//   Optional build macro: MULDIV_EARLY_OUT_EN
//     When defined, a multiply leaves RUN as soon as the remaining multiplier
//     bits are all zero. Results match the default build; only latency changes.
//
// Ports
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   ex_op_i      0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//                7 MFHI, 8 MFLO; 9-15 are treated as NOP
//   ex_rs_val_i  forwarded rs (dividend / multiplicand / MTHI-MTLO source)
//   ex_rt_val_i  forwarded rt (divisor / multiplier)
//   ex_flush_i   EX instruction squashed; ex_op_i is ignored
//   pipe_hold_i  pipeline frozen elsewhere; no op is accepted
//   md_stall_o   stall request for EX and earlier stages
//   busy_o       engine running (RUN or FIX)
//   done_o       one-cycle pulse in the cycle after a mul/div writes HI/LO
//   div_zero_o   one-cycle pulse alongside done_o when the divisor was zero
//   mf_data_o    HI for MFHI, LO for MFLO, otherwise 0
//   hi_o, lo_o   architectural HI and LO
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ex_op_i,
  input  logic [WIDTH-1:0] ex_rs_val_i,
  input  logic [WIDTH-1:0] ex_rt_val_i,
  input  logic             ex_flush_i,
  input  logic             pipe_hold_i,
  output logic             md_stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] mf_data_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMfhi  = 4'd7;
  localparam logic [3:0] OpMflo  = 4'd8;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic                 is_div_q;
  logic                 dz_q;        // pending op is a divide by zero
  logic                 sign_a_q;
  logic                 sign_b_q;
  logic [WIDTH-1:0]     a_q;         // dividend shift reg, becomes quotient
  logic [WIDTH-1:0]     b_q;         // divisor, or multiplier shifted right
  logic [WIDTH-1:0]     rem_q;
  logic [2*WIDTH-1:0]   mcand_q;     // multiplicand shifted left each step
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 done_q;
  logic                 div_zero_q;

  // Issue decode
  logic             op_valid;
  logic             accept;
  logic             op_signed;
  logic [WIDTH-1:0] rs_abs;
  logic [WIDTH-1:0] rt_abs;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  assign op_valid   = (ex_op_i >= OpMult) && (ex_op_i <= OpMflo);
  assign busy_o     = (state_q != StIdle);
  assign md_stall_o = busy_o && op_valid && !ex_flush_i;
  assign accept     = op_valid && !ex_flush_i && !pipe_hold_i && !md_stall_o;

  assign op_signed = (ex_op_i == OpMult) || (ex_op_i == OpDiv);
  assign rs_abs    = ex_rs_val_i[WIDTH-1] ? -ex_rs_val_i : ex_rs_val_i;
  assign rt_abs    = ex_rt_val_i[WIDTH-1] ? -ex_rt_val_i : ex_rt_val_i;
  assign opa       = op_signed ? rs_abs : ex_rs_val_i;
  assign opb       = op_signed ? rt_abs : ex_rt_val_i;

  // One iteration of each engine
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] mcand_d;
  logic [WIDTH-1:0]   b_shift_d;
  logic [WIDTH:0]     trial;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   a_div_d;
  logic               run_exit;

  always_comb begin
    acc_d     = b_q[0] ? (acc_q + mcand_q) : acc_q;
    mcand_d   = mcand_q << 1;
    b_shift_d = b_q >> 1;
    // Restoring step: shift the next dividend bit into the remainder and
    // keep the difference only when it does not go negative.
    trial     = {rem_q, a_q[WIDTH-1]} - {1'b0, b_q};
    q_bit     = ~trial[WIDTH];
    rem_d     = q_bit ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], a_q[WIDTH-1]};
    a_div_d   = {a_q[WIDTH-2:0], q_bit};
`ifdef MULDIV_EARLY_OUT_EN
    // acc_q already holds the full product once no multiplier bits remain,
    // because the multiplicand is shifted rather than the accumulator.
    run_exit  = (cnt_q == LastIter) || (!is_div_q && (b_shift_d == '0));
`else
    run_exit  = (cnt_q == LastIter);
`endif
  end

  // Final sign correction
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -a_q : a_q;
    rem_fix  = sign_a_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      dz_q       <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            unique case (ex_op_i)
              OpMult, OpMultu: begin
                is_div_q <= 1'b0;
                dz_q     <= 1'b0;
                sign_a_q <= op_signed & ex_rs_val_i[WIDTH-1];
                sign_b_q <= op_signed & ex_rt_val_i[WIDTH-1];
                mcand_q  <= {{WIDTH{1'b0}}, opa};
                b_q      <= opb;
                acc_q    <= '0;
                cnt_q    <= '0;
                state_q  <= StRun;
              end
              OpDiv, OpDivu: begin
                is_div_q <= 1'b1;
                cnt_q    <= '0;
                rem_q    <= '0;
                if (ex_rt_val_i == '0) begin
                  // Keep the raw dividend so FIX can return it in HI.
                  dz_q     <= 1'b1;
                  sign_a_q <= 1'b0;
                  sign_b_q <= 1'b0;
                  a_q      <= ex_rs_val_i;
                  b_q      <= '0;
                  state_q  <= StFix;
                end else begin
                  dz_q     <= 1'b0;
                  sign_a_q <= op_signed & ex_rs_val_i[WIDTH-1];
                  sign_b_q <= op_signed & ex_rt_val_i[WIDTH-1];
                  a_q      <= opa;
                  b_q      <= opb;
                  state_q  <= StRun;
                end
              end
              OpMthi:  hi_q <= ex_rs_val_i;
              OpMtlo:  lo_q <= ex_rs_val_i;
              default: ;  // MFHI/MFLO read combinationally
            endcase
          end
        end
        StRun: begin
          cnt_q <= cnt_q + CntW'(1);
          if (is_div_q) begin
            a_q   <= a_div_d;
            rem_q <= rem_d;
          end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            b_q     <= b_shift_d;
          end
          if (run_exit) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          if (!is_div_q) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (dz_q) begin
            hi_q <= a_q;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          done_q     <= 1'b1;
          div_zero_q <= dz_q;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    mf_data_o = '0;
    if (ex_op_i == OpMfhi) begin
      mf_data_o = hi_q;
    end else if (ex_op_i == OpMflo) begin
      mf_data_o = lo_q;
    end
  end

  assign done_o     = done_q;
  assign div_zero_o = div_zero_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed steps plus randomized
// mul/div/move ops, compared against a plain-arithmetic HI/LO model.
module tb_muldiv_sequencer;

  localparam logic [3:0] Nop   = 4'd0;
  localparam logic [3:0] Mult  = 4'd1;
  localparam logic [3:0] Multu = 4'd2;
  localparam logic [3:0] Div   = 4'd3;
  localparam logic [3:0] Divu  = 4'd4;
  localparam logic [3:0] Mthi  = 4'd5;
  localparam logic [3:0] Mtlo  = 4'd6;
  localparam logic [3:0] Mfhi  = 4'd7;
  localparam logic [3:0] Mflo  = 4'd8;

  logic        clk;
  logic        rst_n;
  logic [3:0]  ex_op;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic        ex_flush;
  logic        pipe_hold;
  logic        md_stall;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] mf_data;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors;
  int miscompares;

  logic [31:0] hi_m;
  logic [31:0] lo_m;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_op_i     (ex_op),
    .ex_rs_val_i (ex_rs_val),
    .ex_rt_val_i (ex_rt_val),
    .ex_flush_i  (ex_flush),
    .pipe_hold_i (pipe_hold),
    .md_stall_o  (md_stall),
    .busy_o      (busy),
    .done_o      (done),
    .div_zero_o  (div_zero),
    .mf_data_o   (mf_data),
    .hi_o        (hi),
    .lo_o        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Move-to op, one cycle, with model update only when the op is accepted.
  task automatic mt(input logic [3:0] op, input logic [31:0] val, input logic fl,
                    input logic hold);
    ex_op     = op;
    ex_rs_val = val;
    ex_flush  = fl;
    pipe_hold = hold;
    step();
    ex_op     = Nop;
    ex_flush  = 1'b0;
    pipe_hold = 1'b0;
    if (!fl && !hold) begin
      if (op == Mthi) hi_m = val;
      else            lo_m = val;
    end
    chk("mt_hi", {32'h0, hi}, {32'h0, hi_m});
    chk("mt_lo", {32'h0, lo}, {32'h0, lo_m});
  endtask

  task automatic mf(input logic [3:0] op);
    ex_op = op;
    #1;
    chk(op == Mfhi ? "mfhi" : "mflo", {32'h0, mf_data},
        {32'h0, (op == Mfhi) ? hi_m : lo_m});
    step();
    ex_op = Nop;
  endtask

  // Issue a mul/div, then hold a dependent MFLO in EX until the stall drops.
  task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    logic [31:0] eh;
    logic [31:0] el;
    logic        edz;
    logic [63:0] p;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [31:0] mag;
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    int          exp_stall;
    int          stall_cnt;
    int          iters;
    sa  = longint'($signed(rs));
    sb  = longint'($signed(rt));
    ua  = {32'h0, rs};
    ub  = {32'h0, rt};
    edz = 1'b0;
    exp_stall = 33;
    case (op)
      Mult:  p = 64'(sa * sb);
      Multu: p = ua * ub;
      Div: begin
        if (rt == 0) begin
          edz = 1'b1;
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (rt == 0) begin
          edz = 1'b1;
        end else begin
          p = {32'h0, 32'((ua % ub))} << 32 | (ua / ub);
        end
      end
    endcase
    if (edz) begin
      eh = rs;
      el = 32'hFFFF_FFFF;
      exp_stall = 1;
    end else begin
      eh = p[63:32];
      el = p[31:0];
    end
`ifdef MULDIV_EARLY_OUT_EN
    if (op == Mult || op == Multu) begin
      mag = (op == Mult && rt[31]) ? -rt : rt;
      iters = 1;
      for (int i = 0; i < 32; i++) if (mag[i]) iters = i + 1;
      exp_stall = iters + 1;
    end
`else
    mag   = rt;
    iters = 0;
`endif
    ex_op     = op;
    ex_rs_val = rs;
    ex_rt_val = rt;
    ex_flush  = 1'b0;
    pipe_hold = 1'b0;
    #1;
    chk("issue_no_stall", {63'h0, md_stall}, 64'h0);
    step();
    ex_op = Mflo;
    stall_cnt = 0;
    while (md_stall && stall_cnt < 100) begin
      stall_cnt++;
      pipe_hold = 1'($urandom_range(0, 1));
      step();
    end
    pipe_hold = 1'b0;
    chk("stall_cycles", 64'(stall_cnt), 64'(exp_stall));
    chk("done_pulse", {63'h0, done}, 64'h1);
    chk("div_zero", {63'h0, div_zero}, {63'h0, edz});
    chk("busy_low", {63'h0, busy}, 64'h0);
    chk("res_hi", {32'h0, hi}, {32'h0, eh});
    chk("res_lo", {32'h0, lo}, {32'h0, el});
    chk("mflo_after", {32'h0, mf_data}, {32'h0, el});
    hi_m = eh;
    lo_m = el;
    step();
    ex_op = Nop;
    chk("done_end", {62'h0, done, div_zero}, 64'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    hi_m        = '0;
    lo_m        = '0;
    rst_n       = 1'b0;
    ex_op       = Nop;
    ex_rs_val   = '0;
    ex_rt_val   = '0;
    ex_flush    = 1'b0;
    pipe_hold   = 1'b0;
    repeat (2) step();
    chk("rst_outputs", {hi, lo}, 64'h0);
    chk("rst_flags", {60'h0, busy, done, div_zero, md_stall}, 64'h0);
    rst_n = 1'b1;
    step();

    // Reset mid-RUN aborts the op and clears HI/LO.
    mt(Mthi, 32'h1111_2222, 1'b0, 1'b0);
    mt(Mtlo, 32'h3333_4444, 1'b0, 1'b0);
    ex_op     = Mult;
    ex_rs_val = 32'd7;
    ex_rt_val = 32'd9;
    step();
    ex_op = Nop;
    repeat (9) @(posedge clk);
    #1;
    chk("midrun_busy", {63'h0, busy}, 64'h1);
    ex_op = Mflo;
    rst_n = 1'b0;
    #1;
    chk("midrst_hilo", {hi, lo}, 64'h0);
    chk("midrst_flags", {62'h0, busy, md_stall}, 64'h0);
    step();
    rst_n = 1'b1;
    hi_m  = '0;
    lo_m  = '0;
    step();
    chk("postrst_busy", {63'h0, busy}, 64'h0);
    mf(Mflo);

    // Directed mul/div cases
    run_op(Mult, 32'hFFFF_FFFE, 32'd3);
    run_op(Multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(Multu, 32'd5, 32'd1);
    run_op(Div, 32'hFFFF_FFF9, 32'd2);
    run_op(Div, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(Divu, 32'h0000_1234, 32'd0);
    run_op(Div, 32'hFFFF_FF00, 32'd0);
    run_op(Mult, 32'h8000_0000, 32'h8000_0000);
    mf(Mfhi);

    // Flush and hold gate move-to ops.
    mt(Mthi, 32'hAAAA_0000, 1'b1, 1'b0);
    mt(Mtlo, 32'h0000_0055, 1'b0, 1'b1);
    mt(Mtlo, 32'h0000_0055, 1'b0, 1'b0);

    // Flushed op never stalls while busy; a stalled MTHI lands after the result.
    ex_op     = Multu;
    ex_rs_val = 32'd3;
    ex_rt_val = 32'd5;
    step();
    ex_op     = Mthi;
    ex_rs_val = 32'hDEAD_0000;
    ex_flush  = 1'b1;
    #1;
    chk("flush_no_stall", {63'h0, md_stall}, 64'h0);
    step();
    ex_flush = 1'b0;
    #1;
    chk("mthi_stall", {63'h0, md_stall}, 64'h1);
    for (int i = 0; i < 100 && md_stall; i++) step();
    chk("mthi_wait_res", {hi, lo}, 64'h0000_0000_0000_000F);
    step();
    ex_op = Nop;
    hi_m  = 32'hDEAD_0000;
    lo_m  = 32'h0000_000F;
    chk("mthi_after", {hi, lo}, {hi_m, lo_m});

    // Randomized ops
    for (int n = 0; n < 24; n++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 4'($urandom_range(1, 4));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = b & 32'h0000_00FF;
        1: a = a & 32'h0000_FFFF;
        2: if (op >= Div) b = 32'h0;
        3: a = 32'h8000_0000;
        default: ;
      endcase
      run_op(op, a, b);
      if ($urandom_range(0, 2) == 0) mt(Mthi, $urandom, 1'b0, 1'b0);
      if ($urandom_range(0, 2) == 0) mt(Mtlo, $urandom, 1'b0, 1'b0);
      mf(Mfhi);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
